// File: rtl/branch_pc_ctrl.sv
// Branch/jump resolution, PC register, misaligned-target trap FSM and
// saturating branch statistics for the single-cycle core.
module branch_pc_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             instr_valid,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic             A_eq_B,
  input  logic             A_lt_B,
  input  logic             A_ltu_B,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      imm,
  input  logic             trap_ack,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             br_taken,
  output logic             trap,
  output logic [31:0]      trap_epc,
  output logic [31:0]      trap_tval,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_TRAP = 1'b1;

  logic        state;
  logic        cond;
  logic        cond_branch;
  logic        misaligned;
  logic [31:0] target;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = A_eq_B;
      3'b001:  cond = !A_eq_B;
      3'b100:  cond = A_lt_B;
      3'b101:  cond = !A_lt_B;
      3'b110:  cond = A_ltu_B;
      3'b111:  cond = !A_ltu_B;
      default: cond = 1'b0;
    endcase
  end

  // jalr > jal > branch: a conditional branch only counts when neither jump is flagged
  assign cond_branch = is_branch & !is_jal & !is_jalr;

  always_comb begin
    if (is_jalr) target = (rs1_data + imm) & ~32'h1;
    else         target = pc + imm;
  end

  assign br_taken   = instr_valid & (state == ST_RUN) &
                      (is_jalr | is_jal | (cond_branch & cond));
  assign misaligned = br_taken & target[1];
  assign pc_plus4   = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= ST_RUN;
      trap       <= 1'b0;
      trap_epc   <= '0;
      trap_tval  <= '0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (!stall) begin
      case (state)
        ST_RUN: begin
          if (instr_valid) begin
            if (misaligned) begin
              pc        <= TRAP_VECTOR;
              trap_epc  <= pc;
              trap_tval <= target;
              trap      <= 1'b1;
              state     <= ST_TRAP;
            end else begin
              pc <= br_taken ? target : pc_plus4;
              if (cond_branch) begin
                if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
                if (br_taken && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          if (trap_ack) begin
            trap  <= 1'b0;
            state <= ST_RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Self-checking bench for branch_pc_ctrl: directed scenarios followed by
// random traffic, all compared against an operand-level reference model.
module tb_branch_pc_ctrl;

  localparam int unsigned CW = 4;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst, stall, instr_valid, is_branch, is_jal, is_jalr;
  logic [2:0]    funct3;
  logic          A_eq_B, A_lt_B, A_ltu_B;
  logic [31:0]   rs1_data, imm;
  logic          trap_ack;
  logic [31:0]   pc, pc_plus4, trap_epc, trap_tval;
  logic          br_taken, trap;
  logic [CW-1:0] branch_cnt, taken_cnt;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_pc   = '0;
  logic [31:0] m_epc  = '0;
  logic [31:0] m_tval = '0;
  bit          m_trap = 1'b0;
  int          m_bc   = 0;
  int          m_tc   = 0;

  always #5 clk = ~clk;

  branch_pc_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .TRAP_VECTOR(TV),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .instr_valid(instr_valid),
    .is_branch  (is_branch),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .funct3     (funct3),
    .A_eq_B     (A_eq_B),
    .A_lt_B     (A_lt_B),
    .A_ltu_B    (A_ltu_B),
    .rs1_data   (rs1_data),
    .imm        (imm),
    .trap_ack   (trap_ack),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .br_taken   (br_taken),
    .trap       (trap),
    .trap_epc   (trap_epc),
    .trap_tval  (trap_tval),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Branch outcome decided from the actual operands rather than the flags.
  function automatic bit cond_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input bit v, input bit br, input bit jl, input bit jr,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r1, input logic [31:0] im,
                      input bit ack, input bit st, input bit r);
    logic [31:0] tgt;
    bit tk, mis, isbr;
    @(negedge clk);
    rst = r; stall = st; instr_valid = v; is_branch = br; is_jal = jl; is_jalr = jr;
    funct3 = f3; rs1_data = r1; imm = im; trap_ack = ack;
    A_eq_B = (a == b); A_lt_B = ($signed(a) < $signed(b)); A_ltu_B = (a < b);

    isbr = br && !jl && !jr;
    tgt  = jr ? ((r1 + im) & 32'hFFFF_FFFE) : (m_pc + im);
    tk   = v && !m_trap && (jr || jl || (isbr && cond_of(f3, a, b)));
    mis  = tk && tgt[1];
    #1;
    if (!r) begin
      check("br_taken", {31'b0, br_taken}, {31'b0, tk});
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
    end

    if (r) begin
      m_pc = '0; m_trap = 0; m_epc = '0; m_tval = '0; m_bc = 0; m_tc = 0;
    end else if (!st) begin
      if (m_trap) begin
        if (ack) m_trap = 0;
      end else if (v) begin
        if (mis) begin
          m_epc = m_pc; m_tval = tgt; m_pc = TV; m_trap = 1;
        end else begin
          m_pc = tk ? tgt : m_pc + 32'd4;
          if (isbr) begin
            if (m_bc < 15) m_bc++;
            if (tk && m_tc < 15) m_tc++;
          end
        end
      end
    end

    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("trap", {31'b0, trap}, {31'b0, m_trap});
    check("trap_epc", trap_epc, m_epc);
    check("trap_tval", trap_tval, m_tval);
    check("branch_cnt", {28'b0, branch_cnt}, m_bc);
    check("taken_cnt", {28'b0, taken_cnt}, m_tc);
  endtask

  task automatic nop();
    step(1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jal(input logic [31:0] im, input bit st);
    step(1, 0, 1, 0, 3'd0, 0, 0, 0, im, 0, st, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    // reset and straight-line execution
    step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
    check("reset_pc", pc, 32'h0);
    nop(); nop(); nop();
    check("seq_pc", pc, 32'hC);
    check("seq_cnt", {28'b0, branch_cnt}, 32'h0);

    // BLT taken backwards from 0x40
    jal(32'h34, 0);
    check("jal_pc", pc, 32'h40);
    step(1, 1, 0, 0, 3'd4, 32'hFFFF_FFFB, 32'h3, 0, 32'hFFFF_FFF0, 0, 0, 0);
    check("blt_pc", pc, 32'h30);
    check("blt_bcnt", {28'b0, branch_cnt}, 32'h1);
    check("blt_tcnt", {28'b0, taken_cnt}, 32'h1);
    jal(32'h10, 0);
    step(1, 1, 0, 0, 3'd7, 32'h5, 32'h9, 0, 32'hFFFF_FFF0, 0, 0, 0);
    check("bgeu_pc", pc, 32'h44);

    // JALR to an odd-halfword target traps
    jal(32'h3C, 0);
    step(1, 0, 0, 1, 3'd0, 0, 0, 32'h1003, 32'h0, 0, 0, 0);
    check("trap_flag", {31'b0, trap}, 32'h1);
    check("trap_pc", pc, 32'h100);
    check("trap_epc_k", trap_epc, 32'h80);
    check("trap_tval_k", trap_tval, 32'h1002);
    jal(32'h8, 0);
    step(1, 1, 0, 0, 3'd0, 0, 0, 0, 32'h8, 0, 0, 0);
    step(1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1, 1, 0);
    check("trap_hold_pc", pc, 32'h100);
    step(1, 0, 1, 0, 3'd0, 0, 0, 0, 32'h40, 1, 0, 0);
    check("ack_pc", pc, 32'h100);
    nop();
    check("resume_pc", pc, 32'h104);

    // stall freezes a taken JAL
    step(1, 0, 0, 1, 3'd0, 0, 0, 32'h20, 32'h0, 0, 0, 0);
    jal(32'h40, 1);
    check("stall_pc", pc, 32'h20);
    jal(32'h40, 0);
    check("unstall_pc", pc, 32'h60);

    // reserved condition still counts, then saturate
    step(1, 1, 0, 0, 3'd2, 0, 0, 0, 32'h8, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step(1, 1, 0, 0, 3'd0, 32'h7, 32'h7, 0, 32'h0, 0, 0, 0);
    check("sat_bcnt", {28'b0, branch_cnt}, 32'hF);
    check("sat_tcnt", {28'b0, taken_cnt}, 32'hF);

    // random traffic
    step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      int k;
      k  = $urandom_range(0, 3);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      step($urandom_range(0, 7) != 0, k == 1, k == 2, k == 3, 3'($urandom_range(0, 7)),
           ra, rb, $urandom, $urandom & 32'hFFFF_FFFE,
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    end

    // reset beats stall while trapped
    step(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 3'd0, 1, 1, 0, 32'h4, 0, 0, 0);
    step(1, 0, 0, 1, 3'd0, 0, 0, 32'h3, 32'h0, 0, 0, 0);
    check("pre_rst_trap", {31'b0, trap}, 32'h1);
    step(1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 1, 1);
    check("rst_pc", pc, 32'h0);
    check("rst_trap", {31'b0, trap}, 32'h0);
    check("rst_cnt", {28'b0, branch_cnt}, 32'h0);
    nop();
    check("rst_run_pc", pc, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
